// File: rtl/hex_entry_loader.sv
// hex_entry_loader: builds a hex word from key strobes and writes it to memory by req/ack (HEX_LOADER_AUTOINC_EN enables address auto-increment)
module hex_entry_loader #(
    parameter int ADDR_W     = 7,
    parameter int DATA_W     = 16,
    parameter int START_ADDR = 0
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              digit_strobe_i,
    input  logic [3:0]        digit_i,
    input  logic              commit_strobe_i,
    input  logic              clear_strobe_i,
    input  logic              addr_strobe_i,
    output logic              wr_req_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [DATA_W-1:0] wr_data_o,
    input  logic              wr_ack_i,
    output logic [DATA_W-1:0] entry_word_o,
    output logic [2:0]        digit_count_o,
    output logic [3:0]        state_o,
    output logic              busy_o
);
    localparam int N = DATA_W / 4;
    typedef enum logic [3:0] {IDLE = 4'd0, COLLECT = 4'd1, READY = 4'd2, WRITE = 4'd3} state_t;
    state_t            state_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [DATA_W-1:0] wr_data_q, entry_q;
    logic [2:0]        count_q;
    logic              wr_req_q, busy_q;
    logic              has_digits;
    assign has_digits    = (state_q == COLLECT) || (state_q == READY);
    assign wr_req_o      = wr_req_q;
    assign wr_addr_o     = wr_addr_q;
    assign wr_data_o     = wr_data_q;
    assign entry_word_o  = entry_q;
    assign digit_count_o = count_q;
    assign state_o       = state_q;
    assign busy_o        = busy_q;
    // Entry FSM: one winning strobe per cycle, write held until acknowledged
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q   <= IDLE;
            wr_addr_q <= ADDR_W'(START_ADDR);
            wr_data_q <= '0;
            entry_q   <= '0;
            count_q   <= '0;
            wr_req_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else if (state_q == WRITE) begin
            if (wr_ack_i) begin
                state_q  <= IDLE;
                entry_q  <= '0;
                count_q  <= '0;
                wr_req_q <= 1'b0;
                busy_q   <= 1'b0;
`ifdef HEX_LOADER_AUTOINC_EN
                wr_addr_q <= wr_addr_q + ADDR_W'(1);
`endif
            end
        end else if (clear_strobe_i) begin
            state_q <= IDLE;
            entry_q <= '0;
            count_q <= '0;
        end else if (commit_strobe_i) begin
            if (has_digits) begin
                state_q   <= WRITE;
                wr_data_q <= entry_q;
                wr_req_q  <= 1'b1;
                busy_q    <= 1'b1;
            end
        end else if (addr_strobe_i) begin
            if (has_digits) begin
                state_q   <= IDLE;
                wr_addr_q <= entry_q[ADDR_W-1:0];
                entry_q   <= '0;
                count_q   <= '0;
            end
        end else if (digit_strobe_i && state_q != READY) begin
            entry_q <= {entry_q[DATA_W-5:0], digit_i};
            count_q <= count_q + 3'd1;
            state_q <= (int'(count_q) + 1 == N) ? READY : COLLECT;
        end
    end
endmodule

// File: doc/hex_entry_loader.md
# hex_entry_loader

Front-panel word entry and memory write block; the input-direction counterpart of the hex display path. Debounced key strobes and switch nibbles build a hex word four digits at a time. The block then issues a request/acknowledge write of that word into processor memory at an auto-managed address. It sits between the key filter/switch inputs and the processor's memory write port, and exposes its entry word, digit count and state for the 7-segment display mux.

## Interface
- ADDR_W, 7: write address width; matches the program counter width
- DATA_W, 16: word width; must be a multiple of 4
- START_ADDR, 0: address loaded on reset
- Clk  in  1  system clock; all logic rising-edge
- Reset  in  1  synchronous, active-low reset; sampled on the Clk rising edge
- DigitStrobe  in  1  one-cycle pulse: shift in Digit
- Digit  in  4  hex nibble from switches
- CommitStrobe  in  1  one-cycle pulse: write EntryWord to memory
- ClearStrobe  in  1  one-cycle pulse: discard entry
- AddrStrobe  in  1  one-cycle pulse: load address from entry
- WrReq  out  1  write request, level, held until acknowledged
- WrAddr  out  ADDR_W  write address
- WrData  out  DATA_W  write data
- WrAck  in  1  memory acknowledge
- EntryWord  out  DATA_W  word under construction
- DigitCount  out  3  digits entered, 0..DATA_W/4
- State  out  4  FSM state code, for display
- Busy  out  1  high while in WRITE

## Operation
- FSM states, with their State codes:
  - IDLE=0: no digits entered
  - COLLECT=1: 1..N-1 digits, where N=DATA_W/4
  - READY=2: N digits
  - WRITE=3: request outstanding
- Digit entry:
  - Each accepted DigitStrobe does EntryWord <= {EntryWord[DATA_W-5:0], Digit} and DigitCount+1.
  - The word is right-justified: the first digit entered is the most significant once N digits are in.
- Transitions:
  - From IDLE, a digit moves to COLLECT.
  - From COLLECT, the digit that brings DigitCount to N moves to READY.
  - In READY, DigitStrobe is ignored and no digits are dropped.
- Commit:
  - Accepted in COLLECT or READY. Ignored in IDLE, because a zero-digit commit is a no-op.
  - On accept: WrData <= EntryWord, then go to WRITE.
- Write completion:
  - In WRITE, on WrAck=1: go to IDLE, clear EntryWord and DigitCount, and WrAddr <= WrAddr+1.
  - The address increment wraps 2^ADDR_W-1 -> 0.
- Clear: in IDLE, COLLECT or READY, zeroes EntryWord and DigitCount and goes to IDLE.
- AddrStrobe:
  - Accepted in COLLECT or READY: WrAddr <= EntryWord[ADDR_W-1:0], clear the entry, go to IDLE.
  - Ignored in IDLE.
- Strobes are ignored during WRITE; a started write cannot be aborted except by Reset.
- Priority when strobes coincide in the same cycle: ClearStrobe > CommitStrobe > AddrStrobe > DigitStrobe. Only the winner acts.
- WrAck is ignored while WrReq=0.

## Timing
- Reset values: WrReq=0, WrAddr=START_ADDR, WrData=0, EntryWord=0, DigitCount=0, State=0, Busy=0.
- Strobe effects are visible on the outputs one cycle after the strobe cycle.
- Write request:
  - WrReq and Busy rise on the edge that accepts CommitStrobe.
  - WrAddr and WrData stay stable while WrReq=1.
  - WrAck may arrive in the first WrReq cycle or any later cycle.
  - WrReq falls on the edge that samples WrAck=1, and WrAddr increments on that same edge.
  - Minimum request length is 1 cycle; there is no timeout.
- After a write, WrData holds the last written word until the next commit.
- Reset asserted mid-write drops WrReq on the next edge; the write is abandoned and the address returns to START_ADDR.
- Back-to-back: a commit is not accepted in the cycle WRITE exits. It is accepted at the earliest on the next edge, after fresh digits.

## Configuration
- HEX_LOADER_AUTOINC_EN
  - Defined: WrAddr increments (with wrap) after each acknowledged write, as above.
  - Undefined: WrAddr changes only on reset or accepted AddrStrobe, so repeated commits overwrite the same location.
  - All other behaviour is identical in both cases.

## Test plan
- Reset low one cycle, then digits 1,2,3,4 -> EntryWord=16'h1234, DigitCount=4, State=2; a fifth digit 5 -> EntryWord stays 16'h1234.
- Digits A,B then commit, WrAck held high -> one-cycle WrReq with WrData=16'h00AB, WrAddr=0; then WrAddr=1, State=0, EntryWord=0.
- WrAck withheld 5 cycles -> WrReq, WrAddr and WrData stable for all 5 cycles; DigitStrobe and ClearStrobe during the wait are ignored.
- Digits 7,F then AddrStrobe, then entry 16'hBEEF and commit -> write at address 7'h7F, after which WrAddr wraps to 0 (HEX_LOADER_AUTOINC_EN defined) or stays 7'h7F (undefined).
- ClearStrobe and CommitStrobe in the same cycle with 2 digits entered -> no WrReq, EntryWord=0, State=0.
- Reset asserted while WrReq=1 -> WrReq=0 next edge, WrAddr=START_ADDR, all outputs at reset values.
